// File: rtl/dp_pkg.sv
// dp_pkg: shared state encoding and element-size helpers for the operand fetcher
package dp_pkg;
  typedef enum logic [1:0] {IDLE, RD_A, RD_B, DRAIN} dp_fetch_state_t;
  function automatic int elem_bytes(input int data_w);
    return data_w / 8;
  endfunction
  localparam int ELEM_BYTES = elem_bytes(32);
endpackage

// File: rtl/dp_pair_fifo.sv
// dp_pair_fifo: first-word fall-through buffer; head reads as zero while empty
module dp_pair_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[rd];
  always_ff @(posedge clk) if (push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(push);
      rd <= rd + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/dp_operand_fetcher.sv
// dp_operand_fetcher: reads A[i]/B[i] pairs one beat at a time and streams them out
module dp_operand_fetcher
  import dp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [31:0]       length,
  output logic              busy,
  output logic              done,
  output logic              read_req,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_data_valid,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [DATA_W-1:0] pair_a,
  output logic [DATA_W-1:0] pair_b,
  output logic              pair_last
);
  localparam int EB = elem_bytes(DATA_W);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  dp_fetch_state_t state, state_n;
  logic [ADDR_W-1:0] base_a, base_b, off, read_addr_n;
  logic [31:0] len, idx;
  logic [DATA_W-1:0] a_q;
  logic req_n, done_n, beat, push, pop, last, full, empty;
  logic [CW-1:0] count;
  logic [2*DATA_W:0] dout;
  assign beat = read_req && read_data_valid;
  assign last = idx == len - 32'd1;
  assign push = state == RD_B && beat && !full;
  assign pop = pair_valid && pair_ready;
  assign pair_valid = !empty;
  assign {pair_a, pair_b, pair_last} = dout;
  assign busy = state != IDLE;
  assign off = ADDR_W'(idx) * ADDR_W'(EB);
  dp_pair_fifo #(.WIDTH(2*DATA_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din({a_q, read_data, last}), .pop(pop),
    .dout(dout), .full(full), .empty(empty), .count(count)
  );
  // read_req is a registered "pending" flag: it drops for one cycle after every beat
  always_comb begin
    state_n = state;
    req_n = beat ? 1'b0 : read_req;
    read_addr_n = read_addr;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        if (start && length == 32'd0) done_n = 1'b1;
        else if (start) begin
          state_n = RD_A;
          req_n = 1'b1;
          read_addr_n = addr_a;
        end
      end
      RD_A: begin
        if (beat) state_n = RD_B;
        else if (!read_req && count < CW'(FIFO_DEPTH)) begin
          req_n = 1'b1;
          read_addr_n = base_a + off;
        end
      end
      RD_B: begin
        if (beat) state_n = last ? DRAIN : RD_A;
        else if (!read_req) begin
          req_n = 1'b1;
          read_addr_n = base_b + off;
        end
      end
      DRAIN: begin
        if (pop && pair_last) begin
          state_n = IDLE;
          done_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      read_req <= 1'b0;
      read_addr <= '0;
      done <= 1'b0;
      idx <= '0;
      len <= '0;
      base_a <= '0;
      base_b <= '0;
      a_q <= '0;
    end else begin
      state <= state_n;
      read_req <= req_n;
      read_addr <= read_addr_n;
      done <= done_n;
      if (state == IDLE && start && length != 32'd0) begin
        base_a <= addr_a;
        base_b <= addr_b;
        len <= length;
        idx <= '0;
      end
      if (state == RD_A && beat) a_q <= read_data;
      if (push) idx <= idx + 32'd1;
    end
  end
endmodule
